// File: rtl/barrel_rot_pkg.sv
// Shared definitions for the pipelined barrel rotator/shifter: mode encodings
// and the per-stage control payload carried alongside the data word.
package barrel_rot_pkg;

  localparam logic [1:0] ROT_ROR = 2'b00;
  localparam logic [1:0] ROT_ROL = 2'b01;
  localparam logic [1:0] ROT_LSR = 2'b10;
  localparam logic [1:0] ROT_ASR = 2'b11;

  // fill is the operand MSB captured at input, so ASR sign-fills correctly in every layer
  typedef struct packed {
    logic [1:0] mode;
    logic       fill;
  } rot_ctrl_t;

  localparam rot_ctrl_t ROT_CTRL_CLR = '{mode: 2'b00, fill: 1'b0};

endpackage

// File: rtl/barrel_rot_pipe_if.sv
// Streaming bus of barrel_rot_pipe: input word channel and result channel.
// Optional macro BARREL_ROT_CARRY_EN adds the out_carry result bit.
interface barrel_rot_pipe_if #(
  parameter int DATA_W = 8
);
  localparam int SH_W = $clog2(DATA_W);

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [SH_W-1:0]   in_amt;
  logic [1:0]        in_mode;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_zero;
`ifdef BARREL_ROT_CARRY_EN
  logic              out_carry;

  modport master (
    output in_valid, in_data, in_amt, in_mode, out_ready,
    input  in_ready, out_valid, out_data, out_zero, out_carry
  );

  modport slave (
    input  in_valid, in_data, in_amt, in_mode, out_ready,
    output in_ready, out_valid, out_data, out_zero, out_carry
  );
`else
  modport master (
    output in_valid, in_data, in_amt, in_mode, out_ready,
    input  in_ready, out_valid, out_data, out_zero
  );

  modport slave (
    input  in_valid, in_data, in_amt, in_mode, out_ready,
    output in_ready, out_valid, out_data, out_zero
  );
`endif

endinterface

// File: rtl/barrel_rot_stage.sv
// One registered 2:1 mux layer of the barrel pipeline: shifts by 2^STAGE when
// amount bit STAGE is set, with its own valid bit and load/advance logic.
module barrel_rot_stage
  import barrel_rot_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int SH_W   = $clog2(DATA_W),
  parameter int STAGE  = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              valid_in,
  input  logic [DATA_W-1:0] data_in,
  input  logic [SH_W-1:0]   amt_in,
  input  rot_ctrl_t         ctrl_in,
`ifdef BARREL_ROT_CARRY_EN
  input  logic              carry_in,
  output logic              carry,
`endif
  input  logic              down_ready,
  output logic              ready,
  output logic              valid,
  output logic [DATA_W-1:0] data,
  output logic [SH_W-1:0]   amt,
  output rot_ctrl_t         ctrl,
  output logic              zero
);

  localparam int SHIFT = 1 << STAGE;
  localparam logic [DATA_W-1:0] FILL_MASK = ~({DATA_W{1'b1}} >> SHIFT);

  logic              valid_r;
  logic [DATA_W-1:0] data_r;
  logic [SH_W-1:0]   amt_r;
  rot_ctrl_t         ctrl_r;
  logic              zero_r;
  logic [DATA_W-1:0] layer_s;
  logic [DATA_W-1:0] next_s;
  logic [SH_W-1:0]   amt_s;

  // An empty stage loads even when downstream is stalled, so bubbles collapse
  assign ready = en & (~valid_r | down_ready);

  // Mux layer: full 2^STAGE shift per mode, selected by this stage's amount bit
  always_comb begin
    layer_s = data_in;
    case (ctrl_in.mode)
      ROT_ROR: layer_s = (data_in >> SHIFT) | (data_in << (DATA_W - SHIFT));
      ROT_ROL: layer_s = (data_in << SHIFT) | (data_in >> (DATA_W - SHIFT));
      ROT_LSR: layer_s = data_in >> SHIFT;
      ROT_ASR: layer_s = (data_in >> SHIFT) | (ctrl_in.fill ? FILL_MASK : {DATA_W{1'b0}});
      default: layer_s = data_in;
    endcase
    if (amt_in[STAGE]) begin
      next_s = layer_s;
    end else begin
      next_s = data_in;
    end
    amt_s        = amt_in;
    amt_s[STAGE] = 1'b0;
  end

`ifdef BARREL_ROT_CARRY_EN
  logic carry_r;
  logic carry_s;

  // Shifts report the last bit dropped; rotations report the bit that wrapped last
  always_comb begin
    carry_s = carry_in;
    if (amt_in[STAGE]) begin
      case (ctrl_in.mode)
        ROT_ROR: carry_s = layer_s[DATA_W-1];
        ROT_ROL: carry_s = layer_s[0];
        default: carry_s = data_in[SHIFT-1];
      endcase
    end else begin
      carry_s = carry_in;
    end
  end

  // Carry register moves in lockstep with the data register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      carry_r <= 1'b0;
    end else if (ready) begin
      carry_r <= carry_s;
    end
  end

  assign carry = carry_r;
`endif

  // Stage payload register; holds whenever the stage does not load
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_r <= 1'b0;
      data_r  <= {DATA_W{1'b0}};
      amt_r   <= {SH_W{1'b0}};
      ctrl_r  <= ROT_CTRL_CLR;
      zero_r  <= 1'b0;
    end else if (ready) begin
      valid_r <= valid_in;
      data_r  <= next_s;
      amt_r   <= amt_s;
      ctrl_r  <= ctrl_in;
      zero_r  <= (next_s == {DATA_W{1'b0}});
    end
  end

  assign valid = valid_r;
  assign data  = data_r;
  assign amt   = amt_r;
  assign ctrl  = ctrl_r;
  assign zero  = zero_r;

endmodule

// File: rtl/barrel_rot_pipe.sv
// Pipelined DATA_W-bit rotate/shift unit (ROR/ROL/LSR/ASR), one stage per amount bit,
// valid/ready flow control. Optional macro BARREL_ROT_CARRY_EN adds out_carry.
module barrel_rot_pipe
  import barrel_rot_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input logic                clk,
  input logic                rst_n,
  input logic                en,
  barrel_rot_pipe_if.slave   bus
);

  localparam int SH_W = $clog2(DATA_W);

  logic              valid_c [SH_W+1];
  logic              ready_c [SH_W+1];
  logic [DATA_W-1:0] data_c  [SH_W+1];
  logic [SH_W-1:0]   amt_c   [SH_W+1];
  rot_ctrl_t         ctrl_c  [SH_W+1];
  logic              zero_c  [SH_W];
`ifdef BARREL_ROT_CARRY_EN
  logic              carry_c [SH_W+1];

  assign carry_c[0]    = 1'b0;
  assign bus.out_carry = carry_c[SH_W];
`endif

  assign valid_c[0]  = bus.in_valid;
  assign data_c[0]   = bus.in_data;
  assign amt_c[0]    = bus.in_amt;
  assign ctrl_c[0]   = '{mode: bus.in_mode, fill: bus.in_data[DATA_W-1]};
  assign ready_c[SH_W] = bus.out_ready;
  assign bus.in_ready  = ready_c[0];

  // The last stage's registers are the output registers
  assign bus.out_valid = valid_c[SH_W];
  assign bus.out_data  = data_c[SH_W];
  assign bus.out_zero  = zero_c[SH_W-1];

  for (genvar k = 0; k < SH_W; k++) begin : g_stage
    barrel_rot_stage #(
      .DATA_W (DATA_W),
      .SH_W   (SH_W),
      .STAGE  (k)
    ) u_stage (
      .clk        (clk),
      .rst_n      (rst_n),
      .en         (en),
      .valid_in   (valid_c[k]),
      .data_in    (data_c[k]),
      .amt_in     (amt_c[k]),
      .ctrl_in    (ctrl_c[k]),
`ifdef BARREL_ROT_CARRY_EN
      .carry_in   (carry_c[k]),
      .carry      (carry_c[k+1]),
`endif
      .down_ready (ready_c[k+1]),
      .ready      (ready_c[k]),
      .valid      (valid_c[k+1]),
      .data       (data_c[k+1]),
      .amt        (amt_c[k+1]),
      .ctrl       (ctrl_c[k+1]),
      .zero       (zero_c[k])
    );
  end

endmodule

// File: tb/tb_barrel_rot_pipe.sv
// Directed self-checking bench for barrel_rot_pipe (DATA_W=8): single ops, amount 0,
// stall, enable freeze and mid-stream reset, with hand-computed expectations.
module tb_barrel_rot_pipe;
  import barrel_rot_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  logic en;
  int   n_cmp = 0;
  int   n_err = 0;
  logic [7:0] src_w [6];
  logic [7:0] exp_w [6];

  barrel_rot_pipe_if #(.DATA_W(8)) bus ();

  barrel_rot_pipe #(.DATA_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input string tag, input logic [1:0] mode, input logic [7:0] d,
                        input logic [2:0] amt, input logic [7:0] exp_d, input logic exp_c);
    bus.in_valid  = 1'b1;
    bus.in_data   = d;
    bus.in_amt    = amt;
    bus.in_mode   = mode;
    bus.out_ready = 1'b1;
    @(negedge clk);
    check({tag, "/in_ready"}, 32'(bus.in_ready), 32'd1);
    step();
    bus.in_valid = 1'b0;
    step();
    check({tag, "/early_valid"}, 32'(bus.out_valid), 32'd0);
    step();
    check({tag, "/valid"}, 32'(bus.out_valid), 32'd1);
    check({tag, "/data"}, 32'(bus.out_data), 32'(exp_d));
    check({tag, "/zero"}, 32'(bus.out_zero), 32'(exp_d == 8'h00));
`ifdef BARREL_ROT_CARRY_EN
    check({tag, "/carry"}, 32'(bus.out_carry), 32'(exp_c));
`else
    if (exp_c !== 1'bx) begin
      // carry expectation only meaningful with the carry port present
    end
`endif
    step();
    check({tag, "/drained"}, 32'(bus.out_valid), 32'd0);
  endtask

  // Streams src_w through the DUT; checks order/count and a frozen output window.
  task automatic run_stream(input string tag, input logic [1:0] mode, input logic [2:0] amt,
                            input int stall_lo, input int stall_hi,
                            input int en_lo, input int en_hi, input int held_idx);
    int sent = 0;
    int recv = 0;
    int hold_lo = (stall_lo >= 0) ? stall_lo : en_lo;
    int hold_hi = (stall_lo >= 0) ? stall_hi : en_hi;
    for (int c = 0; c < 60 && recv < 6; c++) begin
      en            = !(c >= en_lo && c <= en_hi);
      bus.out_ready = !(c >= stall_lo && c <= stall_hi);
      bus.in_valid  = (sent < 6);
      bus.in_amt    = amt;
      bus.in_mode   = mode;
      if (sent < 6) bus.in_data = src_w[sent];
      else          bus.in_data = 8'h00;
      @(negedge clk);
      if (c >= hold_lo && c <= hold_hi) begin
        check({tag, "/held_in_ready"}, 32'(bus.in_ready), 32'd0);
        check({tag, "/held_valid"}, 32'(bus.out_valid), 32'd1);
        check({tag, "/held_data"}, 32'(bus.out_data), 32'(exp_w[held_idx]));
      end
      if (bus.out_valid && bus.out_ready && en) begin
        check({tag, "/order"}, 32'(bus.out_data), 32'(exp_w[recv]));
        recv++;
      end
      if (bus.in_valid && bus.in_ready) sent++;
      step();
    end
    en            = 1'b1;
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b0;
    check({tag, "/count"}, 32'(recv), 32'd6);
    for (int i = 0; i < 4; i++) begin
      check({tag, "/no_dup"}, 32'(bus.out_valid), 32'd0);
      step();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n         = 1'b0;
    en            = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = 8'h00;
    bus.in_amt    = 3'd0;
    bus.in_mode   = ROT_ROR;
    bus.out_ready = 1'b0;
    step();
    step();
    check("rst/valid", 32'(bus.out_valid), 32'd0);
    check("rst/data", 32'(bus.out_data), 32'd0);
    check("rst/zero", 32'(bus.out_zero), 32'd0);
    check("rst/in_ready", 32'(bus.in_ready), 32'd1);
`ifdef BARREL_ROT_CARRY_EN
    check("rst/carry", 32'(bus.out_carry), 32'd0);
`endif
    rst_n = 1'b1;
    step();

    run_op("ror_b4_3", ROT_ROR, 8'hB4, 3'd3, 8'h96, 1'b1);
    run_op("rol_81_1", ROT_ROL, 8'h81, 3'd1, 8'h03, 1'b1);
    run_op("lsr_f0_4", ROT_LSR, 8'hF0, 3'd4, 8'h0F, 1'b0);
    run_op("asr_80_7", ROT_ASR, 8'h80, 3'd7, 8'hFF, 1'b0);
    run_op("lsr_01_1", ROT_LSR, 8'h01, 3'd1, 8'h00, 1'b1);
    run_op("ror_01_7", ROT_ROR, 8'h01, 3'd7, 8'h02, 1'b0);
    run_op("asr_7f_3", ROT_ASR, 8'h7F, 3'd3, 8'h0F, 1'b1);
    run_op("rol_b4_5", ROT_ROL, 8'hB4, 3'd5, 8'h96, 1'b0);
    run_op("asr_c3_2", ROT_ASR, 8'hC3, 3'd2, 8'hF0, 1'b1);
    run_op("ror_5a_0", ROT_ROR, 8'h5A, 3'd0, 8'h5A, 1'b0);
    run_op("rol_5a_0", ROT_ROL, 8'h5A, 3'd0, 8'h5A, 1'b0);
    run_op("lsr_5a_0", ROT_LSR, 8'h5A, 3'd0, 8'h5A, 1'b0);
    run_op("asr_5a_0", ROT_ASR, 8'h5A, 3'd0, 8'h5A, 1'b0);

    // ROL by 4 swaps nibbles; out_ready low in cycles 4..9 holds word 1 at the output
    src_w = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC};
    exp_w = '{8'h21, 8'h43, 8'h65, 8'h87, 8'hA9, 8'hCB};
    run_stream("stall", ROT_ROL, 3'd4, 4, 9, -1, -1, 1);

    // ROR by 1; en low in cycles 3..7 freezes word 0 at the output
    src_w = '{8'h03, 8'h05, 8'h0C, 8'h80, 8'hFF, 8'h10};
    exp_w = '{8'h81, 8'h82, 8'h06, 8'h40, 8'hFF, 8'h08};
    run_stream("enable", ROT_ROR, 3'd1, -1, -1, 3, 7, 0);

    // Three words in flight, consumer stalled, then a one-cycle reset
    bus.out_ready = 1'b0;
    bus.in_mode   = ROT_ROR;
    bus.in_amt    = 3'd0;
    bus.in_data   = 8'hFF;
    bus.in_valid  = 1'b1;
    step();
    step();
    step();
    bus.in_valid = 1'b0;
    check("flush/pre_valid", 32'(bus.out_valid), 32'd1);
    check("flush/pre_data", 32'(bus.out_data), 32'hFF);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("flush/valid", 32'(bus.out_valid), 32'd0);
    check("flush/data", 32'(bus.out_data), 32'd0);
    check("flush/zero", 32'(bus.out_zero), 32'd0);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      check("flush/no_emit", 32'(bus.out_valid), 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
